// File: rtl/nor_gate_pkg.sv
// Shared limits, counter type and saturating-increment helper for the nor_gate block.
package nor_gate_pkg;

  localparam int NOR_GATE_MAX_STAGES = 4;
  localparam int NOR_GATE_MAX_WIDTH  = 64;
  localparam int NOR_GATE_CNT_W      = 16;

  typedef logic [NOR_GATE_CNT_W-1:0] nor_cnt_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic nor_cnt_t nor_cnt_sat_inc(input nor_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nor_gate_stage.sv
// One pipeline stage of the nor_gate block: WIDTH data bits plus a valid bit.
// An asynchronous clear sets the data bits to zero and the valid bit to 0.
module nor_gate_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Data loads every cycle; valid only rides alongside it.
  always_comb begin
    data_d  = data_in;
    valid_d = valid_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/nor_gate.sv
// Bitwise NOR with a STAGES-deep register pipeline and valid tracking.
// Optional saturating all-ones result counter, enabled by defining NOR_GATE_COUNT_EN.
module nor_gate
  import nor_gate_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c
`ifdef NOR_GATE_COUNT_EN
  ,
  output nor_cnt_t         ones_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > NOR_GATE_MAX_WIDTH) begin : g_bad_width
    $error("nor_gate: WIDTH %0d outside 1..%0d", WIDTH, NOR_GATE_MAX_WIDTH);
  end
  if (STAGES < 0 || STAGES > NOR_GATE_MAX_STAGES) begin : g_bad_stages
    $error("nor_gate: STAGES %0d outside 0..%0d", STAGES, NOR_GATE_MAX_STAGES);
  end

  // The result is formed at the input; the pipeline carries it, not the operands.
  logic [WIDTH-1:0] nor_w;
  assign nor_w = ~(a | b);

  if (STAGES == 0) begin : g_comb
    assign c         = nor_w;
    assign out_valid = in_valid;
`ifndef NOR_GATE_COUNT_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif
  end else begin : g_pipe
    logic [WIDTH-1:0] data_w  [0:STAGES];
    logic             valid_w [0:STAGES];

    assign data_w[0]  = nor_w;
    assign valid_w[0] = in_valid;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      nor_gate_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_w[gi]),
        .valid_in  (valid_w[gi]),
        .data_out  (data_w[gi+1]),
        .valid_out (valid_w[gi+1])
      );
    end

    assign c         = data_w[STAGES];
    assign out_valid = valid_w[STAGES];
  end

`ifdef NOR_GATE_COUNT_EN
  nor_cnt_t cnt_d, cnt_q;

  // Counts delivered results where every lane saw a = b = 0.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && (&c)) begin
      cnt_d = nor_cnt_sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: WIDTH=8 instances at STAGES 0..4, a WIDTH=1 truth-table
// instance and, when NOR_GATE_COUNT_EN is defined, a WIDTH=4 instance for the result counter.
module tb_nor_gate;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;

  logic [7:0] c8 [0:4];
  logic       v8 [0:4];
  logic [0:0] c1;
  logic       v1;
  logic [3:0] c4;
  logic       v4;

  int total  = 0;
  int passed = 0;

  // History of applied inputs: index k is the NOR result/valid applied k cycles ago.
  logic [7:0] hist_c [0:4];
  logic       hist_v [0:4];
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

`ifdef NOR_GATE_COUNT_EN
  logic [15:0] unused_cnt8 [0:4];
  logic [15:0] cnt1, cnt4;
`endif

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    nor_gate #(.WIDTH(8), .STAGES(gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a8),
      .b         (b8),
      .out_valid (v8[gi]),
      .c         (c8[gi])
`ifdef NOR_GATE_COUNT_EN
      ,
      .ones_cnt  (unused_cnt8[gi])
`endif
    );
  end

  nor_gate #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a8[0:0]),
    .b         (b8[0:0]),
    .out_valid (v1),
    .c         (c1)
`ifdef NOR_GATE_COUNT_EN
    ,
    .ones_cnt  (cnt1)
`endif
  );

  nor_gate #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a8[3:0]),
    .b         (b8[3:0]),
    .out_valid (v4),
    .c         (c4)
`ifdef NOR_GATE_COUNT_EN
    ,
    .ones_cnt  (cnt4)
`endif
  );

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vv);
    a8 = va;
    b8 = vb;
    in_valid = vv;
    hist_c[0] = ~(va | vb);
    hist_v[0] = vv;
  endtask

  task automatic model_clear();
    for (int k = 1; k < 5; k++) begin
      hist_c[k] = '0;
      hist_v[k] = 1'b0;
    end
    exp_cnt = 0;
  endtask

  // Advance one rising edge and update the model, then settle 1 time unit past the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (hist_v[1] && hist_c[1][3:0] == 4'hF && exp_cnt != 32'hFFFF) exp_cnt++;
      for (int k = 4; k >= 1; k--) begin
        hist_c[k] = hist_c[k-1];
        hist_v[k] = hist_v[k-1];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    drive(8'h00, 8'h00, 1'b1);
    #2;
    for (int s = 1; s < 5; s++) begin
      total++;
      if (c8[s] !== 8'h00 || v8[s] !== 1'b0)
        $display("FAIL reset_init s%0d: got c=%h v=%b, required c=00 v=0", s, c8[s], v8[s]);
      else passed++;
    end
    total++;
    if (c8[0] !== 8'hFF || v8[0] !== 1'b1)
      $display("FAIL reset_init s0: got c=%h v=%b, required c=ff v=1", c8[0], v8[0]);
    else passed++;
    cycle();
    rst = 1'b0;
    // Load the pipelines with live data before the mid-stream reset.
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 8'($urandom), 1'b1);
      cycle();
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    for (int s = 1; s < 5; s++) begin
      total++;
      if (c8[s] !== 8'h00 || v8[s] !== 1'b0)
        $display("FAIL reset_async s%0d: got c=%h v=%b, required c=00 v=0", s, c8[s], v8[s]);
      else passed++;
    end
    total++;
    if (c1 !== 1'b0 || v1 !== 1'b0)
      $display("FAIL reset_async w1: got c=%b v=%b, required c=0 v=0", c1, v1);
    else passed++;
`ifdef NOR_GATE_COUNT_EN
    total++;
    if (cnt4 !== 16'd0)
      $display("FAIL reset_async cnt: got %0d, required 0", cnt4);
    else passed++;
`endif
    cycle();
    rst = 1'b0;
    drive(8'h00, 8'h00, 1'b1);
    #1;
    total++;
    if (v8[1] !== 1'b0)
      $display("FAIL reset_first_pre: got v=%b, required v=0", v8[1]);
    else passed++;
    cycle();
    drive(8'h00, 8'h00, 1'b0);
    #1;
    total++;
    if (v8[1] !== 1'b1 || c8[1] !== 8'hFF)
      $display("FAIL reset_first_post: got c=%h v=%b, required c=ff v=1", c8[1], v8[1]);
    else passed++;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab  [0:4] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic       exp [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive({7'b0, ab[i][1]}, {7'b0, ab[i][0]}, 1'b1);
      cycle();
      total++;
      if (c1 !== exp[i] || v1 !== 1'b1)
        $display("FAIL truth ab=%b: got c=%b v=%b, required c=%b v=1", ab[i], c1, v1, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_latency_sweep();
    drive(8'hF0, 8'h0C, 1'b1);
    #1;
    for (int t = 0; t < 6; t++) begin
      for (int s = 0; s < 5; s++) begin
        total++;
        if (s == t && (c8[s] !== 8'h03 || v8[s] !== 1'b1))
          $display("FAIL latency s%0d t%0d: got c=%h v=%b, required c=03 v=1", s, t, c8[s], v8[s]);
        else if (s != t && (c8[s] !== hist_c[s] || v8[s] !== hist_v[s]))
          $display("FAIL latency s%0d t%0d: got c=%h v=%b, required c=%h v=%b",
                   s, t, c8[s], v8[s], hist_c[s], hist_v[s]);
        else passed++;
      end
      cycle();
      drive(8'hFF, 8'hFF, 1'b0);
      #1;
    end
  endtask

  task automatic test_valid_bubbles();
    logic pat [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   seen = 0;
    for (int t = 0; t < 7; t++) begin
      drive(8'($urandom), 8'($urandom), (t < 4) ? pat[t] : 1'b0);
      #1;
      total++;
      if (t >= 2 && t < 6 && v8[2] !== pat[t-2])
        $display("FAIL bubbles t%0d: got v=%b, required v=%b", t, v8[2], pat[t-2]);
      else if (c8[2] !== hist_c[2] || v8[2] !== hist_v[2])
        $display("FAIL bubbles t%0d: got c=%h v=%b, required c=%h v=%b",
                 t, c8[2], v8[2], hist_c[2], hist_v[2]);
      else passed++;
      if (v8[2] === 1'b1) seen++;
      cycle();
    end
    total++;
    if (seen != 3)
      $display("FAIL bubbles_count: got %0d valid outputs, required 3", seen);
    else passed++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 200; t++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom));
      #1;
      for (int s = 0; s < 5; s++) begin
        total++;
        if (c8[s] !== hist_c[s] || v8[s] !== hist_v[s])
          $display("FAIL random t%0d s%0d: got c=%h v=%b, required c=%h v=%b",
                   t, s, c8[s], v8[s], hist_c[s], hist_v[s]);
        else passed++;
      end
`ifdef NOR_GATE_COUNT_EN
      total++;
      if (32'(cnt4) != exp_cnt)
        $display("FAIL random_cnt t%0d: got %0d, required %0d", t, cnt4, exp_cnt);
      else passed++;
`endif
      cycle();
    end
  endtask

`ifdef NOR_GATE_COUNT_EN
  task automatic test_counter();
    #2;
    rst = 1'b1;
    model_clear();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(8'h00, 8'h00, 1'b1);
      cycle();
    end
    drive(8'h01, 8'h00, 1'b1);
    cycle();
    drive(8'h00, 8'h00, 1'b0);
    cycle();
    cycle();
    total++;
    if (cnt4 !== 16'd3 || exp_cnt != 3)
      $display("FAIL counter_three: got %0d, required 3", cnt4);
    else passed++;
    drive(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 65540; i++) cycle();
    drive(8'h00, 8'h00, 1'b0);
    cycle();
    cycle();
    total++;
    if (cnt4 !== 16'hFFFF)
      $display("FAIL counter_sat: got %h, required ffff", cnt4);
    else passed++;
  endtask
`endif

  initial begin
    for (int k = 0; k < 5; k++) begin
      hist_c[k] = '0;
      hist_v[k] = 1'b0;
    end
    test_reset();
    test_truth_table();
    test_latency_sweep();
    test_valid_bubbles();
    test_random();
`ifdef NOR_GATE_COUNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
